// File: rtl/logistic_pkg.sv
// logistic_pkg: sweep-mode and direction types plus fixed-point constants for the logistic-map synth.
// No ports. ONE and R_MAX are given at the default 16 fraction bits; one_of()/r_max_of()
// derive the same constants for any fraction width.
package logistic_pkg;

    typedef enum logic [1:0] {
        RAMP     = 2'd0,
        PINGPONG = 2'd1,
        HOLD     = 2'd2
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic longint one_of(int frac);
        return longint'(1) << frac;
    endfunction

    function automatic longint r_max_of(int frac);
        return (longint'(4) << frac) - 1;
    endfunction

    localparam int FRAC_DEF = 16;
    localparam longint ONE = one_of(FRAC_DEF);
    localparam longint R_MAX = r_max_of(FRAC_DEF);

endpackage

// File: rtl/logistic_step.sv
// logistic_step: two-stage logistic-map arithmetic, x_next = min(r * x(1-x), 1 - lsb).
// Ports: clk, reset (async, active high); x (Q0.FRAC) and r (Q2.FRAC) operands;
// start latches p = x(1-x); valid flags the following cycle, when x_next (Q0.FRAC)
// holds r*p for the r presented in that cycle.
module logistic_step
    import logistic_pkg::*;
#(
    parameter int FRAC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FRAC-1:0] x,
    input  logic [FRAC+1:0] r,
    input  logic            start,
    output logic [FRAC-1:0] x_next,
    output logic            valid
);

    localparam logic [FRAC:0] ONE_L = (FRAC+1)'(one_of(FRAC));

    logic [FRAC-1:0] p_q, p_d;
    logic            busy_q, busy_d;
    logic [FRAC+1:0] rp;

    always_comb begin
        // x(1-x) never exceeds 0.25, so the product's integer bit is always zero
        p_d = start ? FRAC'(((2*FRAC+1)'(x) * (2*FRAC+1)'(ONE_L - {1'b0, x})) >> FRAC) : p_q;
        busy_d = start;
        rp = (FRAC+2)'(((2*FRAC+2)'(r) * (2*FRAC+2)'(p_q)) >> FRAC);
        x_next = |rp[FRAC+1:FRAC] ? {FRAC{1'b1}} : rp[FRAC-1:0];
        valid = busy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
            busy_q <= 1'b0;
        end else begin
            p_q <= p_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/logistic_synth.sv
// logistic_synth: logistic-map driven bank of square-wave oscillators mixed to 1-bit sigma-delta audio.
// Ports: clk; reset (async, active high); enable freezes everything when low; mode selects the
// r sweep (0 RAMP, 1 PINGPONG, 2/3 HOLD); osc_en masks oscillators into the mix; snd is the
// sigma-delta bit; level counts enabled oscillators that are high; iter_strobe pulses after each x/r update.
module logistic_synth
    import logistic_pkg::*;
#(
    parameter int N_OSC      = 8,
    parameter int ITER_LEN   = 15361,
    parameter int R_INC      = 2,
    parameter int FRAC       = 16,
    parameter int PHASE_BITS = 16,
    parameter int FREQ_RES   = 0,
    parameter int R_START    = 3 << FRAC,
    parameter int X_SEED     = 1 << (FRAC - 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 mode,
    input  logic [N_OSC-1:0]           osc_en,
    output logic                       snd,
    output logic [$clog2(N_OSC+1)-1:0] level,
    output logic                       iter_strobe
);

    localparam int LW = $clog2(N_OSC + 1);
    localparam int AW = $clog2(2 * N_OSC);
    localparam int CW = $clog2(ITER_LEN);
    localparam logic [FRAC+1:0] R_MAX_R = (FRAC+2)'(r_max_of(FRAC));
    localparam logic [FRAC+1:0] R_START_R = (FRAC+2)'(R_START);
    localparam logic [FRAC+1:0] R_INC_R = (FRAC+2)'(R_INC);
    localparam logic [FRAC-1:0] X_SEED_X = FRAC'(X_SEED);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAC-1:0]       x_q, x_d;
    logic [FRAC+1:0]       r_q, r_d;
    dir_e                  dir_q, dir_d;
    logic [FRAC-1:0]       f_q [N_OSC];
    logic [FRAC-1:0]       f_d [N_OSC];
    logic [PHASE_BITS-1:0] phase_q [N_OSC];
    logic [PHASE_BITS-1:0] phase_d [N_OSC];
    logic [LW-1:0]         level_q, level_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic                  snd_q, snd_d;
    logic                  strobe_q, strobe_d;

    logic            start, step_valid, over, r_lo;
    logic [FRAC-1:0] x_step;
    logic [FRAC+2:0] r_up;
    logic [LW-1:0]   lvl;
    logic [AW-1:0]   acc_sum;

    logistic_step #(.FRAC(FRAC)) u_step (
        .clk    (clk),
        .reset  (reset),
        .x      (x_q),
        .r      (r_q),
        .start  (start),
        .x_next (x_step),
        .valid  (step_valid)
    );

    always_comb begin
        start = enable && cnt_q == CW'(ITER_LEN - 1);
        cnt_d = enable ? (start ? '0 : cnt_q + 1'b1) : cnt_q;
        r_up = {1'b0, r_q} + {1'b0, R_INC_R};
        over = r_up > {1'b0, R_MAX_R};
        r_lo = {1'b0, r_q} < {1'b0, R_START_R} + {1'b0, R_INC_R};
        x_d = x_q;
        r_d = r_q;
        dir_d = dir_q;
        f_d = f_q;
        // the update completes even if enable dropped after the p stage was launched
        if (step_valid) begin
            x_d = x_step == '0 ? X_SEED_X : x_step;
            if (mode == RAMP) begin
                r_d = over ? R_START_R : r_up[FRAC+1:0];
                x_d = over ? X_SEED_X : x_d;
            end else if (mode == PINGPONG) begin
                if (dir_q == DIR_UP) begin
                    r_d = over ? R_MAX_R : r_up[FRAC+1:0];
                    dir_d = over ? DIR_DOWN : DIR_UP;
                end else begin
                    r_d = r_lo ? R_START_R : r_q - R_INC_R;
                    dir_d = r_lo ? DIR_UP : DIR_DOWN;
                end
            end
            f_d[0] = x_d;
            for (int i = 1; i < N_OSC; i++) f_d[i] = f_q[i-1];
        end
        lvl = '0;
        for (int i = 0; i < N_OSC; i++) begin
            phase_d[i] = enable ? phase_q[i] + PHASE_BITS'(f_q[i] >> FREQ_RES) : phase_q[i];
            lvl = lvl + LW'(osc_en[i] & phase_q[i][PHASE_BITS-1]);
        end
        level_d = enable ? lvl : level_q;
        // acc < N_OSC and level <= N_OSC, so the sum always fits in AW bits
        acc_sum = acc_q + AW'(level_q);
        snd_d = enable && acc_sum >= AW'(N_OSC);
        acc_d = enable ? (snd_d ? acc_sum - AW'(N_OSC) : acc_sum) : acc_q;
        strobe_d = step_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            x_q <= X_SEED_X;
            r_q <= R_START_R;
            dir_q <= DIR_UP;
            f_q <= '{default: '0};
            phase_q <= '{default: '0};
            level_q <= '0;
            acc_q <= '0;
            snd_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            x_q <= x_d;
            r_q <= r_d;
            dir_q <= dir_d;
            f_q <= f_d;
            phase_q <= phase_d;
            level_q <= level_d;
            acc_q <= acc_d;
            snd_q <= snd_d;
            strobe_q <= strobe_d;
        end
    end

    assign snd = snd_q;
    assign level = level_q;
    assign iter_strobe = strobe_q;

endmodule

// File: tb/tb_logistic_synth.sv
// tb_logistic_synth: directed and randomized checks of logistic_synth against a behavioural model.
module tb_logistic_synth;

    localparam int N = 8;
    localparam int IL = 4;
    localparam int RINC = 'h8000;
    localparam int ONE = 65536;
    localparam int RMAX = 'h3FFFF;
    localparam int RST0 = 'h30000;
    localparam int XS = 'h8000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic [1:0] mode = 2'd2;
    logic [N-1:0] osc_en = '1;
    logic snd, iter_strobe;
    logic [3:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    int mx, mr, mp, mcnt, macc, mlvl;
    bit mdir_up, mpend, msnd, mstb;
    int mf[N];
    int mph[N];

    always #5 clk = ~clk;

    logistic_synth #(
        .N_OSC(N), .ITER_LEN(IL), .R_INC(RINC), .FRAC(16), .PHASE_BITS(16), .FREQ_RES(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .osc_en(osc_en),
        .snd(snd), .level(level), .iter_strobe(iter_strobe)
    );

    task automatic check(string tag, longint got, longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = XS; mr = RST0; mp = 0; mcnt = 0; macc = 0; mlvl = 0;
        mdir_up = 1; mpend = 0; msnd = 0; mstb = 0;
        for (int i = 0; i < N; i++) begin
            mf[i] = 0;
            mph[i] = 0;
        end
    endtask

    task automatic model_step();
        bit upd = mpend;
        bit start = 0;
        int nx = mx;
        int nr = mr;
        int nl = 0;
        int s;
        if (upd) begin
            nx = int'((longint'(mr) * mp) >> 16);
            if (nx > ONE - 1) nx = ONE - 1;
            if (nx == 0) nx = XS;
            if (mode == 0) begin
                if (mr + RINC > RMAX) begin
                    nr = RST0;
                    nx = XS;
                end else nr = mr + RINC;
            end else if (mode == 1) begin
                if (mdir_up) begin
                    if (mr + RINC > RMAX) begin
                        nr = RMAX;
                        mdir_up = 0;
                    end else nr = mr + RINC;
                end else begin
                    if (mr - RINC < RST0) begin
                        nr = RST0;
                        mdir_up = 1;
                    end else nr = mr - RINC;
                end
            end
        end
        if (enable) begin
            for (int i = 0; i < N; i++) if (osc_en[i] && mph[i] >= ONE / 2) nl++;
            s = macc + mlvl;
            msnd = s >= N;
            macc = msnd ? s - N : s;
            mlvl = nl;
            for (int i = 0; i < N; i++) mph[i] = (mph[i] + mf[i]) % ONE;
            start = mcnt == IL - 1;
            mcnt = (mcnt + 1) % IL;
        end else msnd = 0;
        if (start) mp = int'((longint'(mx) * (ONE - mx)) >> 16);
        mpend = start;
        if (upd) begin
            mx = nx;
            mr = nr;
            for (int i = N - 1; i > 0; i--) mf[i] = mf[i-1];
            mf[0] = nx;
        end
        mstb = upd;
    endtask

    task automatic compare_all();
        check("x", dut.x_q, mx);
        check("r", dut.r_q, mr);
        check("level", level, mlvl);
        check("snd", snd, msnd);
        check("strobe", iter_strobe, mstb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_strobe();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = iter_strobe;
        end
        check("strobe_seen", seen, 1);
    endtask

    initial begin
        int pp_exp[5];
        int n_hi;
        pp_exp[0] = 'h38000; pp_exp[1] = 'h3FFFF; pp_exp[2] = 'h37FFF;
        pp_exp[3] = 'h30000; pp_exp[4] = 'h38000;
        #2;
        enable = 1'b1;
        mode = 2'd2;
        do_reset();
        check("rst_x", dut.x_q, XS);
        check("rst_r", dut.r_q, RST0);
        check("rst_cnt", dut.cnt_q, 0);

        wait_strobe();
        check("hold_x0", dut.x_q, 'hC000);
        check("hold_r0", dut.r_q, RST0);

        mode = 2'd0;
        do_reset();
        wait_strobe();
        check("ramp_r1", dut.r_q, 'h38000);
        wait_strobe();
        check("ramp_wrap_r", dut.r_q, 'h30000);
        check("ramp_wrap_x", dut.x_q, 'h8000);

        mode = 2'd1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_strobe();
            check($sformatf("pp_r%0d", k), dut.r_q, pp_exp[k]);
        end

        mode = 2'd2;
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_after_t_x", dut.x_q, 'h8000);
        compare_all();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_early_strobe", iter_strobe, 0);
        end
        tick();
        check("first_step_at_t", iter_strobe, 1);

        mode = 2'd0;
        for (int k = 0; k < 22; k++) tick();
        enable = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        check("frz_cnt", dut.cnt_q, mcnt);
        check("frz_ph0", dut.phase_q[0], mph[0]);
        check("frz_ph7", dut.phase_q[7], mph[7]);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        osc_en = '0;
        n_hi = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k >= 3 && snd) n_hi++;
        end
        check("osc_off_snd", n_hi, 0);
        osc_en = '1;

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) osc_en = N'($urandom);
            enable = $urandom_range(0, 99) < 85;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                compare_all();
                tick();
                reset = 1'b0;
            end else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logistic_synth.md
LOGISTIC_SYNTH -- requirements
Module: logistic_synth

Interface
REQ-001 Parameter N_OSC, default 8: number of square-wave oscillators.
REQ-002 Parameter ITER_LEN, default 15361: clk cycles per logistic-map iteration, minimum 4.
REQ-003 Parameter R_INC, default 2: r step per iteration, in LSBs of Q2.FRAC.
REQ-004 Parameter FRAC, default 16: fraction bits of x (Q0.FRAC) and r (Q2.FRAC).
REQ-005 Parameter PHASE_BITS, default 16: oscillator phase accumulator width; must be at least FRAC-FREQ_RES.
REQ-006 Parameter FREQ_RES, default 0: right shift applied to x to form the phase increment.
REQ-007 Parameter R_START, default 3<<FRAC: lower bound of the r sweep and the reset value of r.
REQ-008 Parameter X_SEED, default 1<<(FRAC-1): reseed value of x (0.5).
REQ-009 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-010 Port reset, input, 1: asynchronous, active-high reset.
REQ-011 Port enable, input, 1: high = run; low = freeze all counters, phases, x and r.
REQ-012 Port mode, input, 2: r sweep mode; 0 = RAMP, 1 = PINGPONG, 2 = HOLD, 3 = HOLD.
REQ-013 Port osc_en, input, N_OSC: per-oscillator mix enable.
REQ-014 Port snd, output, 1: registered 1-bit sigma-delta audio output.
REQ-015 Port level, output, clog2(N_OSC+1): registered count of enabled oscillators whose phase MSB is 1.
REQ-016 Port iter_strobe, output, 1: one-cycle pulse in the cycle after x and r update.

Function
REQ-017 The iteration counter shall count 0..ITER_LEN-1 while enable is high, wrapping to 0; the terminal count is called T.
REQ-018 At the edge ending T, the block shall register p = (x*(2^FRAC-x))>>FRAC; at the next edge, x <= min((r*p)>>FRAC, 2^FRAC-1), truncated.
REQ-019 The r value used in the step shall be the pre-update r; r shall update on the same edge as x.
REQ-020 If the new x equals 0, x shall instead load X_SEED.
REQ-021 RAMP: r <= r+R_INC; if r+R_INC > R_MAX (4<<FRAC)-1, then r <= R_START and x <= X_SEED.
REQ-022 PINGPONG: the direction register is up at reset. Going up, if r+R_INC > R_MAX, then r <= R_MAX and the direction turns down. Going down, if r-R_INC < R_START, then r <= R_START and the direction turns up.
REQ-023 HOLD: r shall remain unchanged; x shall still iterate.
REQ-024 A mode change shall take effect at the next r update; the in-flight p step shall not be aborted.
REQ-025 Frequency delay line: on each x update, f[0] <= new x and f[i] <= f[i-1] for i = 1..N_OSC-1.
REQ-026 Each enabled cycle, phase[i] <= phase[i] + (f[i]>>FREQ_RES), zero-extended or truncated to PHASE_BITS, wrapping modulo 2^PHASE_BITS.
REQ-027 level shall equal popcount(osc_en & phase MSBs), registered with 1-cycle latency.
REQ-028 Sigma-delta: the accumulator is clog2(2*N_OSC) bits. acc' = acc + level; if acc' >= N_OSC, then snd <= 1 and acc <= acc'-N_OSC; otherwise snd <= 0 and acc <= acc'.
REQ-029 While enable is low, snd shall be 0 and level shall hold; on re-enable, operation shall resume from the frozen state with no lost step.
REQ-030 If enable falls between T and the x update, the pending x update shall complete before the freeze.

Reset
REQ-031 Assertion of reset shall immediately and asynchronously force: counter=0, x=X_SEED, r=R_START, direction=up, p=0, all f=0, all phase=0, acc=0, snd=0, level=0, iter_strobe=0.
REQ-032 Reset mid-iteration shall discard any pending p step; the first step after release shall occur at T.

Structure
REQ-033 Package logistic_pkg shall hold the mode enum (RAMP, PINGPONG, HOLD) and localparams R_MAX and ONE (1<<FRAC).
REQ-034 The two-stage map arithmetic shall be sub-module logistic_step (inputs x, r, start; outputs x_next, valid).
REQ-035 Oscillators, the delay line and sigma-delta shall stay in logistic_synth.

Verification
REQ-036 Reset, then FRAC=16 and ITER_LEN=4 with mode=HOLD: the first x shall be 0xC000 (r=3.0, x=0.5), with iter_strobe one cycle later.
REQ-037 RAMP with R_INC=0x8000 and R_START=3<<16: r shall follow 0x38000, 0x3FFFF-limit wrap to 0x30000, with x=0x8000 at the wrap.
REQ-038 PINGPONG with the same parameters: r shall be 0x38000, 0x3FFFF, 0x37FFF, 0x30000, then 0x38000.
REQ-039 Force all f=0x8000 with FREQ_RES=0 and PHASE_BITS=16 and all osc_en=1: level shall alternate 0 and 8 every cycle, and snd shall equal the level MSB, delayed.
REQ-040 With osc_en=0, snd shall stay 0; with enable low for 100 cycles mid-iteration, x, r, phases and the counter shall be unchanged.
REQ-041 Assert reset one cycle after T: x shall be 0x8000 immediately and no iter_strobe shall fire.
